// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage access engine:
// FSM state encoding, load/store funct3 codes and access size masks.
package mem_access_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   // Byte-enable pattern for an access of size funct3[1:0], before lane shifting.
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    size_mask = MASK_B;
         2'd1:    size_mask = MASK_H;
         2'd2:    size_mask = MASK_W;
         default: size_mask = MASK_D;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Valid/ready data bus between the memory-stage access engine (master)
// and the memory system (slave).
interface mem_access_if #(
   parameter int XLEN = 32
);
   logic              bus_req_valid;
   logic              bus_req_ready;
   logic              bus_req_we;
   logic [XLEN-1:0]   bus_req_addr;
   logic [XLEN-1:0]   bus_req_wdata;
   logic [XLEN/8-1:0] bus_req_wstrb;
   logic              bus_rsp_valid;
   logic [XLEN-1:0]   bus_rsp_rdata;
   logic              bus_rsp_err;

   modport master (
      output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
      input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
   );

   modport slave (
      input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
      output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load data alignment: moves the addressed bytes down to
// bit 0 and sign- or zero-extends by funct3. Kept separate so a cache
// read path can reuse it.
module mem_load_align
   import mem_access_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int OFFW = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [OFFW-1:0] offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] shifted;

   // Shift the addressed bytes to the bottom, then extend to full width.
   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      data    = shifted;
      case (funct3)
         F3_LB:   data = XLEN'($signed(shifted[7:0]));
         F3_LH:   data = XLEN'($signed(shifted[15:0]));
         F3_LW:   data = XLEN'($signed(shifted[31:0]));
         F3_LBU:  data = XLEN'(shifted[7:0]);
         F3_LHU:  data = XLEN'(shifted[15:0]);
         F3_LWU:  data = XLEN'(shifted[31:0]);
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data access engine. Checks alignment, runs one valid/ready
// bus transaction per load/store and returns extended load data, holding
// the pipeline through mem_stall while the access is outstanding.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort bus waits longer
// than TIMEOUT_CYCLES with an access fault.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [XLEN-1:0]   ex_addr,
   input  logic [XLEN-1:0]   ex_wdata,
   input  logic [2:0]        ex_funct3,
   input  logic              flush,
   mem_access_if.master      bus,
   output logic              mem_stall,
   output logic              done,
   output logic [XLEN-1:0]   load_data,
   output logic              misaligned,
   output logic              access_fault
);

   localparam int OFFW = $clog2(XLEN/8);
   localparam int NB   = XLEN/8;

   if (!(XLEN == 32 || XLEN == 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mem_access_unit: XLEN must be 32 or 64 and TIMEOUT_CYCLES at least 1");
   end

   mem_state_e      state, state_nxt;
   logic            req_we_q, rd_q, kill_q, err_q;
   logic [XLEN-1:0] req_addr_q, req_wdata_q;
   logic [NB-1:0]   req_wstrb_q;
   logic [2:0]      funct3_q;
   logic [OFFW-1:0] offset_q;

   logic            is_req, is_mis, is_bad;
   logic [OFFW-1:0] offset;
   logic [15:0]     strb_wide;
   logic [NB-1:0]   wstrb_new;
   logic [XLEN-1:0] wdata_new;
   logic [XLEN-1:0] aligned_load;
   logic            timeout_hit;

   // Decode the EX/MEM slot: request detection, alignment, legality and byte lanes.
   always_comb begin
      is_req = ex_valid & (ex_mem_read | ex_mem_write) & ~flush;
      offset = ex_addr[OFFW-1:0];
      case (ex_funct3[1:0])
         2'd0:    is_mis = 1'b0;
         2'd1:    is_mis = ex_addr[0];
         2'd2:    is_mis = |ex_addr[1:0];
         default: is_mis = |ex_addr[2:0];
      endcase
      is_bad    = (ex_funct3 == 3'b111) ||
                  ((XLEN == 32) && (ex_funct3 == F3_LD || ex_funct3 == F3_LWU));
      strb_wide = 16'(size_mask(ex_funct3[1:0])) << offset;
      wstrb_new = ex_mem_write ? strb_wide[NB-1:0] : '0;
      wdata_new = ex_mem_write ? (ex_wdata << {offset, 3'b000}) : '0;
   end

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;

   // Count cycles spent waiting on the bus; zero again before each new request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tmo_cnt <= '0;
      else if (state == ST_IDLE)
         tmo_cnt <= '0;
      else if (state == ST_REQ || state == ST_RSP)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign timeout_hit = (state == ST_REQ || state == ST_RSP) &&
                        (tmo_cnt >= CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state plus the stall, completion and exception outputs.
   always_comb begin
      state_nxt    = state;
      mem_stall    = 1'b0;
      done         = 1'b0;
      misaligned   = 1'b0;
      access_fault = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_req) begin
               if (is_mis)
                  misaligned = 1'b1;
               else if (is_bad)
                  access_fault = 1'b1;
               else begin
                  mem_stall = 1'b1;
                  state_nxt = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            mem_stall = 1'b1;
            if (timeout_hit)
               state_nxt = ST_DONE;
            else if (bus.bus_req_ready)
               state_nxt = ST_RSP;
         end
         ST_RSP: begin
            mem_stall = 1'b1;
            if (timeout_hit || bus.bus_rsp_valid)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done         = ~kill_q;
            access_fault = err_q & ~kill_q;
            state_nxt    = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Latch the bus request when it issues so it stays stable through REQ.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_we_q    <= 1'b0;
         rd_q        <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wstrb_q <= '0;
         funct3_q    <= '0;
         offset_q    <= '0;
      end else if (state == ST_IDLE && state_nxt == ST_REQ) begin
         req_we_q    <= ex_mem_write;
         rd_q        <= ex_mem_read;
         req_addr_q  <= {ex_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
         req_wdata_q <= wdata_new;
         req_wstrb_q <= wstrb_new;
         funct3_q    <= ex_funct3;
         offset_q    <= offset;
      end
   end

   // Track flush kill and bus error; a faulted or killed load leaves load_data untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kill_q    <= 1'b0;
         err_q     <= 1'b0;
         load_data <= '0;
      end else if (state == ST_IDLE) begin
         kill_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (state == ST_REQ || state == ST_RSP) begin
         if (flush)
            kill_q <= 1'b1;
         if (timeout_hit)
            err_q <= 1'b1;
         else if (state == ST_RSP && bus.bus_rsp_valid) begin
            err_q <= bus.bus_rsp_err;
            if (rd_q && !kill_q && !flush && !bus.bus_rsp_err)
               load_data <= aligned_load;
         end
      end
   end

   mem_load_align #(.XLEN(XLEN)) u_load_align (
      .rdata  (bus.bus_rsp_rdata),
      .offset (offset_q),
      .funct3 (funct3_q),
      .data   (aligned_load)
   );

   assign bus.bus_req_valid = (state == ST_REQ);
   assign bus.bus_req_we    = req_we_q;
   assign bus.bus_req_addr  = req_addr_q;
   assign bus.bus_req_wdata = req_wdata_q;
   assign bus.bus_req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32). Each transaction is
// described by its bus delays, flush point, error bit and read data; the
// expected per-cycle outputs follow from that timeline and are compared
// against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int TMO    = 4;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 255;
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, flush = 1'b0;
   logic [31:0] ex_addr = '0, ex_wdata = '0;
   logic [2:0]  ex_funct3 = '0;
   logic        mem_stall, done, misaligned, access_fault;
   logic [31:0] load_data;

   mem_access_if #(.XLEN(32)) bus ();

   mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ex_valid     (ex_valid),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_addr      (ex_addr),
      .ex_wdata     (ex_wdata),
      .ex_funct3    (ex_funct3),
      .flush        (flush),
      .bus          (bus),
      .mem_stall    (mem_stall),
      .done         (done),
      .load_data    (load_data),
      .misaligned   (misaligned),
      .access_fault (access_fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   logic        exp_stall, exp_valid, exp_we, exp_done, exp_mis, exp_fault;
   logic [31:0] exp_addr, exp_wdata, model_load;
   logic [3:0]  exp_wstrb;
   logic        check_en = 1'b0;
   logic        obs_start = 1'b0;

   int          obs_cycle, obs_stall, obs_done, obs_fault_at;
   logic        obs_mis, obs_valid_seen, obs_we;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_wstrb;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic clearExp();
      exp_stall = 0; exp_valid = 0; exp_we = 0; exp_done = 0; exp_mis = 0; exp_fault = 0;
      exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
   endtask

   task automatic quietBus();
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rsp_rdata = '0;
      bus.bus_rsp_err   = 1'b0;
   endtask

   // Reference load result: pick the addressed bytes, then fill the upper bytes.
   function automatic logic [31:0] loadRef(input logic [2:0] f3, input int off, input logic [31:0] rdata);
      logic [31:0] r;
      logic        sgn;
      int          nbytes;
      nbytes = 1 << f3[1:0];
      r = '0;
      for (int i = 0; i < nbytes; i++) r[8*i +: 8] = rdata[8*(off+i) +: 8];
      sgn = r[8*nbytes-1];
      if (!f3[2])
         for (int i = nbytes; i < 4; i++) r[8*i +: 8] = {8{sgn}};
      return r;
   endfunction

   // Compare every output against the expected timeline and record observations.
   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            if (obs_start) begin
               obs_cycle = 0; obs_stall = 0; obs_done = -1; obs_fault_at = -1;
               obs_mis = 0; obs_valid_seen = 0; obs_we = 0;
               obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
            end
            checkOutput("mem_stall", mem_stall, exp_stall);
            checkOutput("bus_req_valid", bus.bus_req_valid, exp_valid);
            checkOutput("done", done, exp_done);
            checkOutput("misaligned", misaligned, exp_mis);
            checkOutput("access_fault", access_fault, exp_fault);
            checkOutput("load_data", load_data, model_load);
            if (exp_valid) begin
               checkOutput("bus_req_addr", bus.bus_req_addr, exp_addr);
               checkOutput("bus_req_we", bus.bus_req_we, exp_we);
               checkOutput("bus_req_wstrb", bus.bus_req_wstrb, exp_wstrb);
               if (exp_we) checkOutput("bus_req_wdata", bus.bus_req_wdata, exp_wdata);
            end
            if (mem_stall) obs_stall++;
            if (done && obs_done < 0) obs_done = obs_cycle;
            if (access_fault && obs_fault_at < 0) obs_fault_at = obs_cycle;
            if (misaligned) obs_mis = 1;
            if (bus.bus_req_valid) begin
               obs_valid_seen = 1; obs_we = bus.bus_req_we; obs_addr = bus.bus_req_addr;
               obs_wdata = bus.bus_req_wdata; obs_wstrb = bus.bus_req_wstrb;
            end
            obs_cycle++;
         end
      end
   end

   // One memory instruction from IDLE presentation through its DONE cycle.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] f3, input int rdy_dly,
                                input int rsp_dly, input int flush_at, input logic err,
                                input logic [31:0] rdata);
      int   nbytes, off, total, done_at;
      logic ok, kill, tmo;
      nbytes = 1 << f3[1:0];
      off    = int'(addr[1:0]);
      @(posedge clk); #1;
      ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_addr = addr;
      ex_wdata = wd; ex_funct3 = f3; flush = 0;
      quietBus();
      clearExp();
      obs_start = 1;
      exp_mis   = (rd || wr) && ((addr % nbytes) != 0);
      exp_fault = (rd || wr) && !exp_mis && (f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110);
      ok        = (rd || wr) && !exp_mis && !exp_fault;
      exp_stall = ok;
      if (!ok) return;
      total   = rdy_dly + rsp_dly + 2;
      tmo     = TMO_EN && (total >= TMO);
      done_at = tmo ? TMO : total;
      kill    = 0;
      for (int e = 0; e < done_at; e++) begin
         @(posedge clk); #1;
         obs_start = 0;
         clearExp();
         exp_stall = 1;
         bus.bus_req_ready = (e == rdy_dly);
         bus.bus_rsp_valid = (e == total - 1);
         bus.bus_rsp_rdata = (e == total - 1) ? rdata : $urandom;
         bus.bus_rsp_err   = (e == total - 1) ? err : 1'b0;
         flush = (e == flush_at);
         if (flush) kill = 1;
         if (e <= rdy_dly) begin
            exp_valid = 1;
            exp_we    = wr;
            exp_addr  = {addr[31:2], 2'b00};
            exp_wdata = wd << (8 * off);
            exp_wstrb = wr ? 4'(((1 << nbytes) - 1) << off) : 4'b0;
         end
      end
      @(posedge clk); #1;
      obs_start = 0;
      clearExp();
      flush = 0;
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'($urandom_range(0, 1));
      bus.bus_rsp_rdata = $urandom;
      bus.bus_rsp_err   = 1'($urandom_range(0, 1));
      exp_done  = !kill;
      exp_fault = (err || tmo) && !kill;
      if (rd && !kill && !tmo && !err) model_load = loadRef(f3, off, rdata);
   endtask

   // Cycles with no request presented, plus stray bus responses that must be ignored.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         obs_start = 0;
         clearExp();
         quietBus();
         bus.bus_rsp_valid = 1'($urandom_range(0, 1));
         bus.bus_rsp_rdata = $urandom;
         bus.bus_rsp_err   = 1'($urandom_range(0, 1));
         ex_addr = $urandom; ex_wdata = $urandom; ex_funct3 = 3'($urandom_range(0, 2));
         case ($urandom_range(0, 2))
            0: begin ex_valid = 0; ex_mem_read = 1'($urandom_range(0, 1)); ex_mem_write = 0; flush = 0; end
            1: begin ex_valid = 1; ex_mem_read = 0; ex_mem_write = 0; flush = 0; end
            default: begin ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; flush = 1; end
         endcase
      end
   endtask

   // Assert reset while a load waits in REQ; everything must drop at once.
   task automatic resetMidFlight();
      @(posedge clk); #1;
      ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_addr = 32'h40; ex_funct3 = 3'b010; flush = 0;
      quietBus(); clearExp(); obs_start = 1; exp_stall = 1;
      @(posedge clk); #1;
      obs_start = 0; clearExp(); exp_stall = 1; exp_valid = 1; exp_addr = 32'h40;
      @(posedge clk); #1;
      reset_n = 0; ex_valid = 0; ex_mem_read = 0;
      clearExp(); model_load = '0;
      #1;
      checkOutput("reset_mid_valid", bus.bus_req_valid, 1'b0);
      checkOutput("reset_mid_stall", mem_stall, 1'b0);
      checkOutput("reset_mid_load", load_data, 32'h0);
      @(posedge clk); #1;
      reset_n = 1;
   endtask

   initial begin
      logic        rd, wr, err;
      logic [2:0]  f3;
      logic [31:0] a;
      int          rdy, rsp, fat, nb;
      quietBus();
      clearExp();
      model_load = '0;
      check_en = 1;
      obs_start = 1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      reset_n = 1;
      obs_start = 0;
      $display("[TB] reset released");

      applyStimulus(1, 0, 32'h1000, 32'h0, 3'b010, 0, 0, -1, 0, 32'h8000_00FF);
      @(negedge clk); #1;
      checkOutput("lw_load_data", load_data, 32'h8000_00FF);
      checkOutput("lw_done_cycle", obs_done, 3);
      checkOutput("lw_stall_cycles", obs_stall, 3);
      checkOutput("lw_req_addr", obs_addr, 32'h1000);
      checkOutput("lw_req_wstrb", obs_wstrb, 4'b0000);

      applyStimulus(1, 0, 32'h1003, 32'h0, 3'b000, 0, 0, -1, 0, 32'h8012_3456);
      @(negedge clk); #1;
      checkOutput("lb_sign_ext", load_data, 32'hFFFF_FF80);
      applyStimulus(1, 0, 32'h1003, 32'h0, 3'b100, 1, 2, -1, 0, 32'h8012_3456);
      @(negedge clk); #1;
      checkOutput("lbu_zero_ext", load_data, 32'h0000_0080);

      applyStimulus(0, 1, 32'h2002, 32'h0000_1234, 3'b001, 0, 0, -1, 0, 32'h0);
      @(negedge clk); #1;
      checkOutput("sh_wdata", obs_wdata, 32'h1234_0000);
      checkOutput("sh_wstrb", obs_wstrb, 4'b1100);
      checkOutput("sh_we", obs_we, 1'b1);

      applyStimulus(1, 0, 32'h1001, 32'h0, 3'b010, 0, 0, -1, 0, 32'h0);
      @(negedge clk); #1;
      checkOutput("mis_pulse", obs_mis, 1'b1);
      checkOutput("mis_no_valid", obs_valid_seen, 1'b0);
      checkOutput("mis_no_stall", obs_stall, 0);

      applyStimulus(1, 0, 32'h3000, 32'h0, 3'b010, 5, 0, -1, 1, 32'hDEAD_BEEF);
      @(negedge clk); #1;
      checkOutput("err_done_cycle", obs_done, TMO_EN ? 5 : 8);
      checkOutput("err_fault_cycle", obs_fault_at, TMO_EN ? 5 : 8);

      applyStimulus(1, 0, 32'h3004, 32'h0, 3'b010, 0, 3, 2, 1, 32'h1357_9BDF);
      @(negedge clk); #1;
      checkOutput("flush_no_done", obs_done, -1);
      checkOutput("flush_no_fault", obs_fault_at, -1);
      checkOutput("flush_load_kept", load_data, 32'h0000_0080);

`ifdef MEM_BUS_TIMEOUT_EN
      applyStimulus(1, 0, 32'h5000, 32'h0, 3'b010, 50, 0, -1, 0, 32'h0);
      @(negedge clk); #1;
      checkOutput("tmo_done_cycle", obs_done, 5);
      checkOutput("tmo_fault_cycle", obs_fault_at, 5);
      idleCycles(3);
`endif

      resetMidFlight();
      idleCycles(2);

      for (int t = 0; t < 150; t++) begin
         rd = 1'($urandom_range(0, 1));
         wr = !rd;
         if (rd) f3 = 3'($urandom_range(0, 7));
         else    f3 = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 3));
         nb = 1 << f3[1:0];
         a = $urandom;
         if ($urandom_range(0, 4) != 0) a = a & ~(32'(nb) - 32'd1);
         rdy = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
         rsp = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
         fat = ($urandom_range(0, 6) == 0) ? $urandom_range(0, rdy + rsp + 1) : -1;
         err = ($urandom_range(0, 9) == 0);
         applyStimulus(rd, wr, a, $urandom, f3, rdy, rsp, fat, err, $urandom);
         idleCycles($urandom_range(0, 2));
      end

      idleCycles(2);
      @(negedge clk); #1;
      check_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
